// File: rtl/pkg_serial.sv
// pkg_serial: shared state encoding and idle line level for the serial path
package pkg_serial;
   localparam logic S_IDLE = 1'b0;
   localparam logic S_SHIFT = 1'b1;
   localparam logic IDLE_LEVEL = 1'b0;
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word loader with a one-word holding buffer
// feeding a shifter that drives one bit per clock towards the 1001 detector
module piso_serializer
   import pkg_serial::*;
#(
   parameter int WIDTH = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_active,
   output logic             word_done
);
   localparam int CW = $clog2(WIDTH);
   logic             state;
   logic             hold_full;
   logic [WIDTH-1:0] hold_data;
   logic [WIDTH-2:0] sreg;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             xfer;
   assign load_ready = !hold_full;
   assign accept = load_valid && load_ready;
   // the buffer refills the shifter as the last bit leaves, so words abut
   assign xfer = hold_full && (state == S_IDLE || cnt == '0);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         hold_full  <= 1'b0;
         hold_data  <= '0;
         sreg       <= '0;
         cnt        <= '0;
         ser_out    <= IDLE_LEVEL;
         ser_active <= 1'b0;
         word_done  <= 1'b0;
      end else begin
         word_done <= state == S_SHIFT && cnt == '0;
         if (accept) begin
            hold_data <= data_in;
            hold_full <= 1'b1;
         end else if (xfer) begin
            hold_full <= 1'b0;
         end
         if (xfer) begin
            ser_out    <= MSB_FIRST ? hold_data[WIDTH-1] : hold_data[0];
            sreg       <= MSB_FIRST ? hold_data[WIDTH-2:0] : hold_data[WIDTH-1:1];
            cnt        <= CW'(WIDTH - 1);
            state      <= S_SHIFT;
            ser_active <= 1'b1;
         end else if (state == S_SHIFT && cnt != '0) begin
            ser_out <= MSB_FIRST ? sreg[WIDTH-2] : sreg[0];
            sreg    <= MSB_FIRST ? sreg << 1 : sreg >> 1;
            cnt     <= cnt - 1'b1;
         end else if (state == S_SHIFT) begin
            ser_out    <= IDLE_LEVEL;
            ser_active <= 1'b0;
            state      <= S_IDLE;
         end
      end
   end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks on a 4-bit MSB-first and an 8-bit
// LSB-first serializer sharing one clock and reset
module tb_piso_serializer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] data_a = '0;
   logic valid_a = 1'b0;
   logic ready_a, ser_a, act_a, done_a;
   logic [7:0] data_b = '0;
   logic valid_b = 1'b0;
   logic ready_b, ser_b, act_b, done_b;
   int checks = 0;
   int errors = 0;
   logic [7:0] q[$];

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .reset(reset), .data_in(data_a), .load_valid(valid_a),
      .load_ready(ready_a), .ser_out(ser_a), .ser_active(act_a), .word_done(done_a));

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .reset(reset), .data_in(data_b), .load_valid(valid_b),
      .load_ready(ready_b), .ser_out(ser_b), .ser_active(act_b), .word_done(done_b));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drives the words in q through one instance and checks the bit stream
   task automatic stream(input bit sel, input int budget, input int min_blocked);
      logic [7:0] ws[$];
      bit exp_bits[$];
      bit got_bits[$];
      int w, dones, blocked, first, last;
      bit rdy, acc;
      ws = q;
      w = sel ? 8 : 4;
      foreach (ws[k])
         for (int i = 0; i < w; i++)
            exp_bits.push_back(sel ? ws[k][i] : ws[k][w-1-i]);
      dones = 0; blocked = 0; first = -1; last = -1;
      for (int c = 0; c < budget; c++) begin
         if (sel) begin
            valid_b = q.size() > 0;
            data_b = q.size() > 0 ? q[0] : 8'h00;
            rdy = ready_b;
            acc = valid_b && rdy;
         end else begin
            valid_a = q.size() > 0;
            data_a = q.size() > 0 ? q[0][3:0] : 4'h0;
            rdy = ready_a;
            acc = valid_a && rdy;
         end
         if (q.size() > 0 && !rdy) blocked++;
         tick();
         if (acc) void'(q.pop_front());
         if (sel ? act_b : act_a) begin
            got_bits.push_back(sel ? ser_b : ser_a);
            if (first < 0) first = c;
            last = c;
         end else begin
            check("idle_level", 32'(sel ? ser_b : ser_a), 32'd0);
         end
         dones += int'(sel ? done_b : done_a);
      end
      valid_a = 1'b0;
      valid_b = 1'b0;
      check("stream_len", 32'(got_bits.size()), 32'(exp_bits.size()));
      check("stream_contig", 32'(last - first + 1), 32'(exp_bits.size()));
      check("done_count", 32'(dones), 32'(ws.size()));
      check("words_left", 32'(q.size()), 32'd0);
      check("blocked", 32'(blocked >= min_blocked), 32'd1);
      for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++)
         check($sformatf("bit%0d", i), 32'(got_bits[i]), 32'(exp_bits[i]));
   endtask

   initial begin
      logic [3:0] hist;
      bit exp_a [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      bit any_bad;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("rst_ser", 32'(ser_a), 32'd0);
         check("rst_act", 32'(act_a), 32'd0);
         check("rst_rdy", 32'(ready_a), 32'd1);
         check("rst_rdy_b", 32'(ready_b), 32'd1);
      end
      // single 1001 word, explicit latency checks
      data_a = 4'b1001;
      valid_a = 1'b1;
      tick();
      valid_a = 1'b0;
      check("acc_rdy", 32'(ready_a), 32'd0);
      check("acc_ser", 32'(ser_a), 32'd0);
      hist = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         hist = {hist[2:0], ser_a};
         check($sformatf("w1001_b%0d", i), 32'(ser_a), 32'(exp_a[i]));
         check("w1001_act", 32'(act_a), 32'd1);
         check("w1001_done", 32'(done_a), 32'd0);
      end
      check("det_1001", 32'(hist), 32'b1001);
      tick();
      check("done_pulse", 32'(done_a), 32'd1);
      check("done_ser", 32'(ser_a), 32'd0);
      check("done_act", 32'(act_a), 32'd0);
      tick();
      check("done_clear", 32'(done_a), 32'd0);
      // back-to-back stream with load_valid held
      q = '{8'h0C, 8'h06};
      stream(1'b0, 20, 1);
      q = '{8'h0C, 8'h06, 8'h03};
      stream(1'b0, 24, 1);
      // LSB first, then backpressure on 8'h3C
      q = '{8'hA5};
      stream(1'b1, 14, 0);
      q = '{8'hA5, 8'h3C};
      stream(1'b1, 26, 1);
      // reset mid-word
      data_b = 8'hFF;
      valid_b = 1'b1;
      tick();
      valid_b = 1'b0;
      tick();
      tick();
      check("ff_bit2", 32'(ser_b), 32'd1);
      check("ff_act", 32'(act_b), 32'd1);
      reset = 1'b1;
      #1;
      check("arst_ser", 32'(ser_b), 32'd0);
      check("arst_act", 32'(act_b), 32'd0);
      check("arst_done", 32'(done_b), 32'd0);
      check("arst_rdy", 32'(ready_b), 32'd1);
      tick();
      reset = 1'b0;
      any_bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done_b || act_b || ser_b) any_bad = 1'b1;
      end
      check("post_rst_quiet", 32'(any_bad), 32'd0);
      q = '{8'hA5};
      stream(1'b1, 14, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
